maze_solver: RTL and testbench
==============================

# maze_solver

Depth-first maze explorer that drives the 16×16 single-bit maze memory as its only client. It owns the memory's RD/WR/Din/X/Y pins and samples the memory's Dout. It searches from cell (0,0) to a goal cell, marking visited cells in place. On success it streams the solution path out as a sequence of 2-bit moves over a valid/ready handshake.

## Interface
- GOAL_X, default 4'd15: goal row, the memory X index.
- GOAL_Y, default 4'd15: goal column, the memory Y index.
- Ports (clock and reset first):
  - clk  in  1  system clock; the same clock as the maze memory.
  - rst  in  1  reset, **synchronous, active-high**.
  - Start  in  1  begin a search; honoured only in IDLE.
  - Dout  in  1  memory read data; valid only while RD=1, high-Z otherwise.
  - RD  out  1  memory read enable.
  - WR  out  1  memory write enable.
  - Din  out  1  memory write data.
  - X  out  4  memory row address.
  - Y  out  4  memory column address.
  - Move  out  2  path step: 0=Right (Y+1), 1=Down (X+1), 2=Left (Y−1), 3=Up (X−1).
  - Move_valid  out  1  Move is valid.
  - Move_ready  in  1  consumer accepts Move.
  - Done  out  1  path found; stays high after replay until the next Start.
  - Fail  out  1  no path exists; stays high until the next Start.

## Operation
- Cell encoding: 0 = free and unvisited, 1 = wall or visited. The solver writes 1 into every cell it enters. The maze contents are therefore destroyed, and the memory must be reloaded before a second search.
- States: IDLE, CHECK, MARK, PROBE, BACK, REPLAY, DONE, FAIL.
- IDLE
  - Start=1: clear Done/Fail, set cur=(0,0), sp=0, then go to CHECK.
- CHECK
  - Drive RD=1, X/Y=(0,0).
  - Dout=1 → FAIL; otherwise → MARK.
- MARK
  - Drive WR=1, Din=1, X/Y=cur.
  - If cur=(GOAL_X,GOAL_Y) → REPLAY with ridx=0.
  - Otherwise set dir=0 and go to PROBE.
- PROBE (one cycle per direction)
  - Neighbour out of bounds: RD=0, no memory access. Take the try-next path.
  - Neighbour in bounds: RD=1, X/Y=neighbour.
    - Dout=0: push dir, set cur=neighbour, go to MARK.
    - Dout=1: take the try-next path.
  - Try-next: dir<3 → dir+1 and stay in PROBE; dir=3 → BACK.
- BACK
  - sp=0 → FAIL.
  - Otherwise pop d and set cur = cur stepped opposite to d.
  - d<3 → dir=d+1, go to PROBE; d=3 → stay in BACK.
- REPLAY
  - Move=stack[ridx], Move_valid=1.
  - On Move_valid&&Move_ready: ridx+1. When ridx+1=sp, go to DONE.
  - sp=0 (goal equals start) goes straight to DONE with no moves.
- DONE / FAIL
  - Hold the flag. Start=1 restarts as from IDLE.
- Stack: 256 × 2 bits, sp 8 bits. The maximum path is 255 moves, so the stack cannot overflow. Pop never underflows because BACK checks sp=0 first.
- Coordinate arithmetic is 4-bit unsigned. The out-of-bounds test is on edge values (Y=15 for Right, X=15 for Down, Y=0 for Left, X=0 for Up). The arithmetic never wraps.
- RD and WR are never high in the same cycle. RD=0 and WR=0 in IDLE, REPLAY, DONE and FAIL.

## Timing
- Reset values:
  - RD=0, WR=0, Din=0, X=0, Y=0, Move=0.
  - Move_valid=0, Done=0, Fail=0, state=IDLE, sp=0.
- Reset mid-search returns to IDLE on the next edge. Visited marks already written stay in memory.
- Start outside IDLE/DONE/FAIL is ignored.
- All outputs are registered or decoded from state and registers. Dout is sampled combinationally in the same cycle RD is driven, and acted on at that clock edge.
- Cycle costs:
  - One write per entered cell (MARK).
  - One cycle per probed direction.
  - One cycle per BACK pop.
  - One cycle per accepted Move when Move_ready is held high.
- Move_valid stays high and Move stays stable while Move_ready=0.
- Done rises the cycle after the last Move handshake.
- Fail rises the cycle after the failing CHECK or BACK.

## Structure
- Package maze_pkg holds:
  - dir_t, a 2-bit enum RIGHT/DOWN/LEFT/UP.
  - state_t.
  - MAZE_N=16.
  - A step(dir) function that returns the next coordinate and an out-of-bounds flag.
- Sub-module solver_stack: 256×2 LIFO with push, pop, top, sp and a separate indexed read port for REPLAY.
- The top level holds the FSM, the cur/dir registers and the memory pin drivers. The bench instantiates the solver together with the maze memory.

## Test plan
- All-free maze, Move_ready=1:
  - Move sequence is 15×Right then 15×Down (30 moves).
  - Done=1, Fail=0.
  - Every cell on the path reads 1 afterwards.
- Cell (0,0)=1 → Fail=1 two cycles after Start; WR never asserted.
- Goal walled off, (14,15)=1 and (15,14)=1, rest free:
  - Full exploration and backtracking with no path.
  - Fail=1 and sp returns to 0.
- Dead-end corridor requiring backtrack: only column 0 plus row 15 are free, with a spur at row 0, Y=1..3.
  - Moves are 15×Down then 15×Right.
  - The spur is not in the replay.
- Replay backpressure: toggle Move_ready every other cycle on the all-free maze. Move holds while not ready; same 30-move sequence.
- rst asserted mid-PROBE → next cycle all outputs are at reset values; a new Start after the memory is reloaded succeeds.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | maze_pkg                                                              |
// | Shared types, maze size and neighbour stepping for the maze solver.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package maze_pkg;

  localparam int         MAZE_N  = 16;
  localparam logic [3:0] MAX_IDX = 4'(MAZE_N - 1);

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    MARK   = 3'd2,
    PROBE  = 3'd3,
    BACK   = 3'd4,
    REPLAY = 3'd5,
    DONE   = 3'd6,
    FAIL   = 3'd7
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       oob;
  } step_t;

  // Coordinates are left unchanged when the step would leave the grid.
  function automatic step_t step(input logic [3:0] x, input logic [3:0] y, input dir_t d);
    step_t s;
    s.x   = x;
    s.y   = y;
    s.oob = 1'b0;
    unique case (d)
      RIGHT: if (y == MAX_IDX) s.oob = 1'b1; else s.y = y + 4'd1;
      DOWN:  if (x == MAX_IDX) s.oob = 1'b1; else s.x = x + 4'd1;
      LEFT:  if (y == 4'd0)    s.oob = 1'b1; else s.y = y - 4'd1;
      UP:    if (x == 4'd0)    s.oob = 1'b1; else s.x = x - 4'd1;
      default: s.oob = 1'b1;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/solver_stack.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | solver_stack                                                          |
// | 256 x 2-bit LIFO of moves with an indexed read port for replay.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module solver_stack
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  dir_t       push_data,
  input  logic       pop,
  output dir_t       top,
  output logic [7:0] sp,
  input  logic [7:0] rd_idx,
  output dir_t       rd_data
);

  dir_t       r_mem [256];
  logic [7:0] r_sp;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sp <= 8'd0;
    end else if (push) begin
      r_sp <= r_sp + 8'd1;
    end else if (pop) begin
      r_sp <= r_sp - 8'd1;
    end
  end

  // Storage needs no reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_sp] <= push_data;
    end
  end

  assign top     = r_mem[r_sp - 8'd1];
  assign sp      = r_sp;
  assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/maze_solver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | maze_solver                                                           |
// | Depth-first search over a 16x16 bit maze memory; replays the path.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module maze_solver
  import maze_pkg::*;
#(
  parameter logic [3:0] GOAL_X = 4'd15,
  parameter logic [3:0] GOAL_Y = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       Dout,
  output logic       RD,
  output logic       WR,
  output logic       Din,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic [1:0] Move,
  output logic       Move_valid,
  input  logic       Move_ready,
  output logic       Done,
  output logic       Fail
);

  state_t     r_state, w_state_nx;
  logic [3:0] r_cur_x, r_cur_y, w_cur_x_nx, w_cur_y_nx;
  dir_t       r_dir, w_dir_nx;
  logic [7:0] r_ridx, w_ridx_nx;

  logic       w_clr, w_push, w_pop;
  dir_t       w_top, w_rd_data;
  logic [7:0] w_sp;
  step_t      w_nb, w_bk;

  solver_stack u_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .push      (w_push),
    .push_data (r_dir),
    .pop       (w_pop),
    .top       (w_top),
    .sp        (w_sp),
    .rd_idx    (r_ridx),
    .rd_data   (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cur_x <= 4'd0;
      r_cur_y <= 4'd0;
      r_dir   <= RIGHT;
      r_ridx  <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cur_x <= w_cur_x_nx;
      r_cur_y <= w_cur_y_nx;
      r_dir   <= w_dir_nx;
      r_ridx  <= w_ridx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cur_x_nx = r_cur_x;
    w_cur_y_nx = r_cur_y;
    w_dir_nx   = r_dir;
    w_ridx_nx  = r_ridx;
    w_clr      = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    RD         = 1'b0;
    WR         = 1'b0;
    Din        = 1'b0;
    X          = 4'd0;
    Y          = 4'd0;
    Move       = 2'd0;
    Move_valid = 1'b0;
    w_nb       = step(r_cur_x, r_cur_y, r_dir);
    // Backtracking walks opposite to the popped move (dir XOR 2).
    w_bk       = step(r_cur_x, r_cur_y, dir_t'(w_top ^ 2'd2));

    unique case (r_state)
      IDLE, DONE, FAIL: begin
        if (Start) begin
          w_clr      = 1'b1;
          w_cur_x_nx = 4'd0;
          w_cur_y_nx = 4'd0;
          w_state_nx = CHECK;
        end
      end
      CHECK: begin
        RD         = 1'b1;
        w_state_nx = Dout ? FAIL : MARK;
      end
      MARK: begin
        WR  = 1'b1;
        Din = 1'b1;
        X   = r_cur_x;
        Y   = r_cur_y;
        if (r_cur_x == GOAL_X && r_cur_y == GOAL_Y) begin
          w_ridx_nx  = 8'd0;
          w_state_nx = (w_sp == 8'd0) ? DONE : REPLAY;
        end else begin
          w_dir_nx   = RIGHT;
          w_state_nx = PROBE;
        end
      end
      PROBE: begin
        if (!w_nb.oob) begin
          RD = 1'b1;
          X  = w_nb.x;
          Y  = w_nb.y;
        end
        if (!w_nb.oob && !Dout) begin
          w_push     = 1'b1;
          w_cur_x_nx = w_nb.x;
          w_cur_y_nx = w_nb.y;
          w_state_nx = MARK;
        end else if (r_dir == UP) begin
          w_state_nx = BACK;
        end else begin
          w_dir_nx = dir_t'(r_dir + 2'd1);
        end
      end
      BACK: begin
        if (w_sp == 8'd0 || w_bk.oob) begin
          w_state_nx = FAIL;
        end else begin
          w_pop      = 1'b1;
          w_cur_x_nx = w_bk.x;
          w_cur_y_nx = w_bk.y;
          if (w_top != UP) begin
            w_dir_nx   = dir_t'(w_top + 2'd1);
            w_state_nx = PROBE;
          end
        end
      end
      REPLAY: begin
        Move       = w_rd_data;
        Move_valid = 1'b1;
        if (Move_ready) begin
          w_ridx_nx = r_ridx + 8'd1;
          if (r_ridx + 8'd1 == w_sp) begin
            w_state_nx = DONE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign Done = (r_state == DONE);
  assign Fail = (r_state == FAIL);

endmodule
`default_nettype wire

// File: tb/tb_maze_solver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_maze_solver                                                        |
// | Solver plus maze memory model, DFS reference and move scoreboard.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_maze_solver;
  import maze_pkg::*;

  logic       clk, rst, Start, Dout, RD, WR, Din, Move_valid, Move_ready, Done, Fail;
  logic [3:0] X, Y;
  logic [1:0] Move;

  logic [255:0] mem, img_r, m_vis;
  logic         load;
  logic [1:0]   exp_q[$];
  logic [1:0]   m_path[$];
  bit           m_found, tog_mode, wr_seen, illegal, r_hold;
  logic [1:0]   r_hold_mv;
  int           vectors = 0, errors = 0, cyc = 0, last_hs = 0, last_n = 0;

  maze_solver dut (
    .clk(clk), .rst(rst), .Start(Start), .Dout(Dout), .RD(RD), .WR(WR), .Din(Din),
    .X(X), .Y(Y), .Move(Move), .Move_valid(Move_valid), .Move_ready(Move_ready),
    .Done(Done), .Fail(Fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Maze memory: cell index is {row X, column Y}.
  always @(posedge clk) begin
    if (load) mem <= img_r;
    else if (WR) mem[{X, Y}] <= Din;
  end
  assign Dout = RD ? mem[{X, Y}] : 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dxf(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction
  function automatic int dyf(input int d);
    return (d == 0) ? 1 : (d == 2) ? -1 : 0;
  endfunction

  // Textbook depth-first search: try directions in order, backtrack on dead ends.
  task automatic model(input logic [255:0] img);
    int cx, cy, nx, ny, nd, bd;
    bit fin;
    m_vis = img;
    m_path.delete();
    m_found = 0;
    fin = img[0];
    cx = 0; cy = 0; nd = 0;
    if (!fin) m_vis[0] = 1'b1;
    while (!fin) begin
      if (cx == 15 && cy == 15) begin
        m_found = 1;
        fin = 1;
      end else begin
        bd = -1;
        for (int d = nd; d < 4; d++) begin
          nx = cx + dxf(d);
          ny = cy + dyf(d);
          if (bd < 0 && nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !m_vis[nx*16+ny]) bd = d;
        end
        if (bd >= 0) begin
          cx += dxf(bd);
          cy += dyf(bd);
          m_vis[cx*16+cy] = 1'b1;
          m_path.push_back(2'(bd));
          nd = 0;
        end else if (m_path.size() == 0) begin
          fin = 1;
        end else begin
          bd = int'(m_path.pop_back());
          cx -= dxf(bd);
          cy -= dyf(bd);
          nd = bd + 1;
        end
      end
    end
  endtask

  // Monitor: scoreboard pops on every handshake, checks hold under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      r_hold = 0;
    end else begin
      if (RD && WR) illegal = 1;
      if (WR) wr_seen = 1;
      if (r_hold) begin
        chk("hold_valid", Move_valid, 1);
        chk("hold_move", Move, r_hold_mv);
      end
      r_hold = Move_valid && !Move_ready;
      r_hold_mv = Move;
      if (Move_valid && Move_ready) begin
        if (exp_q.size() == 0) chk("unexpected_move", 1, 0);
        else chk("move", Move, exp_q.pop_front());
        last_hs = cyc;
      end
    end
  end

  initial begin
    Move_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 Move_ready = tog_mode ? ~Move_ready : 1'b1;
    end
  end

  task automatic check_reset(input string nm);
    chk({nm, "_RD"}, RD, 0);     chk({nm, "_WR"}, WR, 0);   chk({nm, "_Din"}, Din, 0);
    chk({nm, "_X"}, X, 0);       chk({nm, "_Y"}, Y, 0);     chk({nm, "_Move"}, Move, 0);
    chk({nm, "_Mv"}, Move_valid, 0); chk({nm, "_Done"}, Done, 0); chk({nm, "_Fail"}, Fail, 0);
    chk({nm, "_sp"}, dut.w_sp, 0);
  endtask

  task automatic load_maze(input logic [255:0] img);
    img_r = img;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // kind: 0 = reference model, 1 = 15R then 15D, 2 = 15D then 15R, 3 = no path.
  task automatic run(input logic [255:0] img, input int kind, input bit tog, input string nm);
    int n, exp_len;
    bit exp_found;
    load_maze(img);
    model(img);
    exp_q.delete();
    exp_found = (kind != 3);
    case (kind)
      0: begin exp_found = m_found; foreach (m_path[i]) exp_q.push_back(m_path[i]); end
      1: begin repeat (15) exp_q.push_back(2'd0); repeat (15) exp_q.push_back(2'd1); end
      2: begin repeat (15) exp_q.push_back(2'd1); repeat (15) exp_q.push_back(2'd0); end
      default: ;
    endcase
    exp_len = exp_q.size();
    wr_seen = 0; illegal = 0; tog_mode = tog;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done && !Fail && n < 20000);
    chk({nm, "_done"}, Done, exp_found);
    chk({nm, "_fail"}, Fail, !exp_found);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_memdiff"}, $countones(mem ^ m_vis), 0);
    chk({nm, "_rdwr"}, illegal, 0);
    if (exp_found && exp_len > 0) chk({nm, "_donelat"}, cyc - last_hs, 1);
    tog_mode = 0;
    last_n = n;
  endtask

  logic [255:0] img;
  int wait_n;

  initial begin
    rst = 1'b1; Start = 1'b0; load = 1'b0; tog_mode = 0; img_r = '0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst = 1'b0;

    run('0, 1, 0, "free");

    img = '0; img[0] = 1'b1;
    run(img, 3, 0, "start_wall");
    chk("start_wall_lat", last_n, 2);
    chk("start_wall_wr", wr_seen, 0);

    img = '0; img[14*16+15] = 1'b1; img[15*16+14] = 1'b1;
    run(img, 3, 0, "walled");
    chk("walled_sp", dut.w_sp, 0);

    img = '1;
    for (int i = 0; i < 16; i++) begin img[i*16] = 1'b0; img[15*16+i] = 1'b0; end
    for (int i = 1; i <= 3; i++) img[i] = 1'b0;
    run(img, 2, 0, "corridor");

    run('0, 1, 1, "backpressure");

    // Reset while probing, then a clean search after reload.
    load_maze('0);
    exp_q.delete();
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (dut.r_state != PROBE && wait_n < 100);
    chk("probe_reached", wait_n < 100, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset("midrst");
    rst = 1'b0;
    run('0, 1, 0, "after_rst");

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) img[k*32 +: 32] = $urandom() & $urandom();
      img[0] = 1'b0;
      img[255] = 1'b0;
      run(img, 0, r[0], $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
